// File: rtl/t10_pkg.sv
// Shared definitions for the period meter and the tick generator it pairs with.
// Both sides take their counter width from T10_PERIOD_W so results line up.
package t10_pkg;

  localparam int T10_PERIOD_W = 30;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } t10_state_e;

endpackage

// File: rtl/t10_edge_detect.sv
// Registers a clk-domain level and emits a one-cycle pulse on its 0->1 transition.
// Latency 0 (combinational pulse from the live input); no backpressure.
module t10_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic sig_i,
  output logic rise_o
);

  logic sig_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig_i;
    end
  end

  // A level already high on the first cycle out of reset reads as a rising edge.
  assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/t10_period_meter.sv
// Measures clk cycles between strobe rising edges; result valid 1 cycle after the edge.
// Single-entry valid/ready slot: a capture into a full, unaccepted slot is dropped and flagged.
module t10_period_meter
  import t10_pkg::*;
#(
  parameter int WIDTH = T10_PERIOD_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             strobe,
  input  logic [WIDTH-1:0] max_period,
  output logic [WIDTH-1:0] period,
  output logic             period_valid,
  input  logic             period_ready,
  output logic             timeout,
  output logic             overrun,
  output logic             busy
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  t10_state_e       state_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] period_q;
  logic             valid_q;
  logic             timeout_q;
  logic             overrun_q;

  logic rise;
  logic at_limit;
  logic count_max;
  logic capture;
  logic accept;

  t10_edge_detect u_edge (
    .clk    (clk),
    .rst    (rst),
    .clear  (clear),
    .sig_i  (strobe),
    .rise_o (rise)
  );

  // Equality only: a limit lowered below the running count never fires for this interval.
  assign at_limit  = (max_period != '0) && (count_q == max_period);
  assign count_max = &count_q;
  assign capture   = (state_q == MEASURE) && rise;
  assign accept    = valid_q && period_ready;

  always_comb begin
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (rise) begin
          count_d = ONE;
        end
      end
      MEASURE: begin
        if (rise) begin
          count_d = ONE;
        end else if (at_limit) begin
          count_d = '0;
        end else if (!count_max) begin
          count_d = count_q + ONE;
        end
      end
      default: count_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state_q   <= IDLE;
      count_q   <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      count_q <= count_d;

      case (state_q)
        IDLE: begin
          if (rise) begin
            state_q <= MEASURE;
          end
        end
        MEASURE: begin
          // An edge landing on the limit cycle is a result, not a timeout.
          if (!rise && at_limit) begin
            state_q   <= IDLE;
            timeout_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (capture) begin
        if (!valid_q || period_ready) begin
          period_q <= count_q;
          valid_q  <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (accept) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign period       = period_q;
  assign period_valid = valid_q;
  assign timeout      = timeout_q;
  assign overrun      = overrun_q;
  assign busy         = (state_q == MEASURE);

endmodule

// File: tb/tb_t10_period_meter.sv
// Timestamp-based reference model feeds a result queue; a negedge monitor checks transfers and flags.
module tb_t10_period_meter;

  localparam int W = 30;
  localparam longint MAXC = (longint'(1) << W) - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         clear = 1'b0;
  logic         strobe = 1'b0;
  logic [W-1:0] max_period = '0;
  logic         period_ready = 1'b0;
  logic [W-1:0] period;
  logic         period_valid;
  logic         timeout;
  logic         overrun;
  logic         busy;

  int checks = 0;
  int failures = 0;

  t10_period_meter #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear),
    .strobe       (strobe),
    .max_period   (max_period),
    .period       (period),
    .period_valid (period_valid),
    .period_ready (period_ready),
    .timeout      (timeout),
    .overrun      (overrun),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a measurement is the difference of two edge timestamps.
  longint cyc_n = 0;
  longint m_ref = 0;
  bit     m_meas = 0;
  bit     m_prev = 0;
  bit     m_valid = 0;
  bit     m_timeout = 0;
  bit     m_overrun = 0;
  bit     mon_en = 0;
  longint exp_q[$];

  always @(posedge clk) begin
    bit     e;
    bit     cap;
    longint el;
    longint capv;
    cyc_n++;
    cap  = 0;
    capv = 0;
    if (rst || clear) begin
      m_meas = 0; m_prev = 0; m_valid = 0; m_timeout = 0; m_overrun = 0;
      exp_q.delete();
      if (rst) mon_en = 1;
    end else begin
      e = strobe && !m_prev;
      m_prev = strobe;
      if (m_meas) begin
        el = cyc_n - m_ref;
        if (e) begin
          cap  = 1;
          capv = (el > MAXC) ? MAXC : el;
          m_ref = cyc_n;
        end else if (max_period != 0 && el == longint'(max_period)) begin
          m_timeout = 1;
          m_meas = 0;
        end
      end else if (e) begin
        m_meas = 1;
        m_ref = cyc_n;
      end
      if (cap) begin
        if (!m_valid || period_ready) begin
          m_valid = 1;
          exp_q.push_back(capv);
        end else begin
          m_overrun = 1;
        end
      end else if (m_valid && period_ready) begin
        m_valid = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      check("period_valid", period_valid, m_valid);
      check("timeout", timeout, m_timeout);
      check("overrun", overrun, m_overrun);
      check("busy", busy, m_meas);
      if (period_valid && period_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", period, -1);
        end else begin
          check("period", period, exp_q.pop_front());
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input int gap);
    strobe = 1'b1;
    tick(1);
    strobe = 1'b0;
    tick(gap - 1);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
  endtask

  initial begin
    // Reset state and 10-cycle train, always ready.
    tick(2);
    check("rst_period", period, 0);
    check("rst_valid", period_valid, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    period_ready = 1'b1;
    for (int k = 0; k < 5; k++) pulse(10);
    check("t1_period", period, 10);

    // Stalled consumer: first result held, later ones dropped.
    do_clear();
    period_ready = 1'b0;
    pulse(7);
    pulse(7);
    strobe = 1'b1;
    tick(1);
    strobe = 1'b0;
    tick(2);
    check("t2_overrun", overrun, 1);
    check("t2_period", period, 7);
    check("t2_valid", period_valid, 1);
    period_ready = 1'b1;
    tick(1);
    period_ready = 1'b0;
    check("t2_valid_drop", period_valid, 0);
    tick(3);
    pulse(3);
    check("t2_reload_valid", period_valid, 1);
    check("t2_reload_period", period, 7);

    // Timeout, then re-arm keeps the sticky flag.
    do_clear();
    period_ready = 1'b1;
    max_period = W'(20);
    pulse(26);
    check("t3_timeout", timeout, 1);
    check("t3_busy", busy, 0);
    pulse(5);
    pulse(3);
    check("t3_period", period, 5);
    check("t3_timeout_sticky", timeout, 1);

    // Edge exactly on the limit cycle.
    do_clear();
    max_period = W'(12);
    pulse(12);
    pulse(3);
    check("t4_period", period, 12);
    check("t4_timeout", timeout, 0);

    // Long high level is a single edge.
    do_clear();
    max_period = '0;
    strobe = 1'b1;
    tick(8);
    strobe = 1'b0;
    tick(4);
    pulse(4);
    check("t5_period", period, 12);

    // Clear mid-measurement with a full slot and overrun set.
    do_clear();
    period_ready = 1'b0;
    pulse(5);
    pulse(5);
    pulse(5);
    check("t6_pre_overrun", overrun, 1);
    do_clear();
    check("t6_period", period, 0);
    check("t6_valid", period_valid, 0);
    check("t6_overrun", overrun, 0);
    check("t6_busy", busy, 0);
    pulse(6);
    check("t6_arm_valid", period_valid, 0);
    check("t6_arm_busy", busy, 1);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      if (i % 200 == 0) begin
        max_period = ($urandom_range(0, 2) == 0) ? W'(0) : W'($urandom_range(2, 40));
      end
      strobe       = ($urandom_range(0, 7) == 0) ? ~strobe : strobe;
      period_ready = ($urandom_range(0, 3) != 0);
      clear        = ($urandom_range(0, 599) == 0);
      tick(1);
    end
    clear = 1'b0;
    strobe = 1'b0;
    period_ready = 1'b1;
    tick(4);
    check("drain_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
